// File: rtl/trap_ctrl_pkg.sv
// Shared constants and types for the trap sequencer: cause codes, FSM encoding,
// and the aligned/vectored trap target helper.
package trap_ctrl_pkg;

  localparam int REG_BUS_D = 32;

  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
  localparam logic [3:0] CAUSE_ECALL_M = 4'd11;
  localparam logic [3:0] CAUSE_LMIS    = 4'd4;
  localparam logic [3:0] CAUSE_SMIS    = 4'd6;
  localparam logic [3:0] CAUSE_MEI     = 4'd11;
  localparam logic [3:0] CAUSE_MSI     = 4'd3;
  localparam logic [3:0] CAUSE_MTI     = 4'd7;

  typedef enum logic [1:0] {
    TRAP_IDLE = 2'b00,
    TRAP_SAVE = 2'b01,
    TRAP_JUMP = 2'b10
  } trap_state_e;

  typedef struct packed {
    logic                 valid;
    logic                 ieType;
    logic [3:0]           cause;
    logic [REG_BUS_D-1:0] mtval;
  } trap_sel_t;

  // Vectored mode only offsets interrupts; exceptions always land on the base.
  function automatic logic [REG_BUS_D-1:0] trapTarget(
    input logic [REG_BUS_D-1:0] mtvec,
    input logic                 ieType,
    input logic [3:0]           cause,
    input logic                 vectoredEn
  );
    logic [REG_BUS_D-1:0] base;
    base = {mtvec[REG_BUS_D-1:2], 2'b00};
    if (vectoredEn && (mtvec[1:0] == 2'b01) && ieType)
      trapTarget = base + REG_BUS_D'({cause, 2'b00});
    else
      trapTarget = base;
  endfunction

endpackage

// File: rtl/trap_ctrl_sel.sv
// trap_sel: combinational priority encoder choosing the trap to take this cycle.
// Exceptions beat mret, and a pending mret masks interrupts for the same cycle.
module trap_sel
  import trap_ctrl_pkg::*;
(
  input  logic                 exc_illegal_i,
  input  logic                 exc_ebreak_i,
  input  logic                 exc_ecall_i,
  input  logic                 exc_lmis_i,
  input  logic                 exc_smis_i,
  input  logic [REG_BUS_D-1:0] exc_inst_i,
  input  logic [REG_BUS_D-1:0] exc_addr_i,
  input  logic                 mret_i,
  input  logic                 commit_i,
  input  logic                 mstatus_ie_i,
  input  logic                 mie_ext_i,
  input  logic                 mie_timer_i,
  input  logic                 mie_sw_i,
  input  logic                 mip_ext_i,
  input  logic                 mip_timer_i,
  input  logic                 mip_sw_i,
  output trap_sel_t            sel_o
);

  logic irqOk;
  logic irqExt;
  logic irqSw;
  logic irqTimer;

  assign irqOk    = mstatus_ie_i && commit_i && !mret_i;
  assign irqExt   = irqOk && mie_ext_i   && mip_ext_i;
  assign irqSw    = irqOk && mie_sw_i    && mip_sw_i;
  assign irqTimer = irqOk && mie_timer_i && mip_timer_i;

  always_comb begin
    sel_o = '0;
    if (exc_illegal_i) begin
      sel_o.valid = 1'b1;
      sel_o.cause = CAUSE_ILLEGAL;
      sel_o.mtval = exc_inst_i;
    end else if (exc_ebreak_i) begin
      sel_o.valid = 1'b1;
      sel_o.cause = CAUSE_EBREAK;
    end else if (exc_ecall_i) begin
      sel_o.valid = 1'b1;
      sel_o.cause = CAUSE_ECALL_M;
    end else if (exc_lmis_i) begin
      sel_o.valid = 1'b1;
      sel_o.cause = CAUSE_LMIS;
      sel_o.mtval = exc_addr_i;
    end else if (exc_smis_i) begin
      sel_o.valid = 1'b1;
      sel_o.cause = CAUSE_SMIS;
      sel_o.mtval = exc_addr_i;
    end else if (irqExt) begin
      sel_o.valid  = 1'b1;
      sel_o.ieType = 1'b1;
      sel_o.cause  = CAUSE_MEI;
    end else if (irqSw) begin
      sel_o.valid  = 1'b1;
      sel_o.ieType = 1'b1;
      sel_o.cause  = CAUSE_MSI;
    end else if (irqTimer) begin
      sel_o.valid  = 1'b1;
      sel_o.ieType = 1'b1;
      sel_o.cause  = CAUSE_MTI;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: IDLE -> SAVE -> JUMP trap sequencer driving csr_file strobes and fetch redirect.
// Define VECTORED_MTVEC_EN to enable vectored interrupt targets when mtvec mode is 2'b01.
module trap_ctrl
  import trap_ctrl_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 n_rst_i,
  input  logic                 commit_i,
  input  logic [REG_BUS_D-1:0] commit_pc_i,
  input  logic [REG_BUS_D-1:0] exc_pc_i,
  input  logic                 exc_illegal_i,
  input  logic                 exc_ebreak_i,
  input  logic                 exc_ecall_i,
  input  logic                 exc_lmis_i,
  input  logic                 exc_smis_i,
  input  logic [REG_BUS_D-1:0] exc_inst_i,
  input  logic [REG_BUS_D-1:0] exc_addr_i,
  input  logic                 mret_i,
  input  logic                 mstatus_ie_i,
  input  logic                 mie_ext_i,
  input  logic                 mie_timer_i,
  input  logic                 mie_sw_i,
  input  logic                 mip_ext_i,
  input  logic                 mip_timer_i,
  input  logic                 mip_sw_i,
  input  logic [REG_BUS_D-1:0] mtvec_i,
  input  logic [REG_BUS_D-1:0] epc_i,
  output logic                 set_cause_o,
  output logic                 ie_type_o,
  output logic [3:0]           trap_cause_o,
  output logic                 set_epc_o,
  output logic [REG_BUS_D-1:0] epc_o,
  output logic                 set_mtval_o,
  output logic [REG_BUS_D-1:0] mtval_o,
  output logic                 mstatus_ie_clear_o,
  output logic                 mstatus_ie_set_o,
  output logic                 stall_o,
  output logic                 flush_o,
  output logic                 redirect_o,
  output logic [REG_BUS_D-1:0] redirect_pc_o
);

`ifdef VECTORED_MTVEC_EN
  localparam logic VectoredEn = 1'b1;
`else
  localparam logic VectoredEn = 1'b0;
`endif

  trap_state_e          state_q, state_d;
  logic                 ieType_q, ieType_d;
  logic [3:0]           cause_q, cause_d;
  logic [REG_BUS_D-1:0] epc_q, epc_d;
  logic [REG_BUS_D-1:0] mtval_q, mtval_d;

  trap_sel_t sel;
  logic      takeTrap;
  logic      takeMret;

  trap_sel u_trap_sel (
    .exc_illegal_i (exc_illegal_i),
    .exc_ebreak_i  (exc_ebreak_i),
    .exc_ecall_i   (exc_ecall_i),
    .exc_lmis_i    (exc_lmis_i),
    .exc_smis_i    (exc_smis_i),
    .exc_inst_i    (exc_inst_i),
    .exc_addr_i    (exc_addr_i),
    .mret_i        (mret_i),
    .commit_i      (commit_i),
    .mstatus_ie_i  (mstatus_ie_i),
    .mie_ext_i     (mie_ext_i),
    .mie_timer_i   (mie_timer_i),
    .mie_sw_i      (mie_sw_i),
    .mip_ext_i     (mip_ext_i),
    .mip_timer_i   (mip_timer_i),
    .mip_sw_i      (mip_sw_i),
    .sel_o         (sel)
  );

  // sel.valid already folds in mret masking interrupts, so mret only loses to exceptions.
  assign takeTrap = (state_q == TRAP_IDLE) && sel.valid;
  assign takeMret = (state_q == TRAP_IDLE) && mret_i && !sel.valid;

  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      state_q  <= TRAP_IDLE;
      ieType_q <= 1'b0;
      cause_q  <= '0;
      epc_q    <= '0;
      mtval_q  <= '0;
    end else begin
      state_q  <= state_d;
      ieType_q <= ieType_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      mtval_q  <= mtval_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ieType_d = ieType_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    mtval_d  = mtval_q;
    unique case (state_q)
      TRAP_IDLE: begin
        if (takeTrap) begin
          state_d  = TRAP_SAVE;
          ieType_d = sel.ieType;
          cause_d  = sel.cause;
          epc_d    = sel.ieType ? commit_pc_i : exc_pc_i;
          mtval_d  = sel.mtval;
        end
      end
      TRAP_SAVE: state_d = TRAP_JUMP;
      TRAP_JUMP: state_d = TRAP_IDLE;
      default:   state_d = TRAP_IDLE;
    endcase
  end

  // Everything is held low while reset is asserted so a mid-trap reset emits no strobes.
  always_comb begin
    set_cause_o        = 1'b0;
    ie_type_o          = 1'b0;
    trap_cause_o       = '0;
    set_epc_o          = 1'b0;
    epc_o              = '0;
    set_mtval_o        = 1'b0;
    mtval_o            = '0;
    mstatus_ie_clear_o = 1'b0;
    mstatus_ie_set_o   = 1'b0;
    stall_o            = 1'b0;
    flush_o            = 1'b0;
    redirect_o         = 1'b0;
    redirect_pc_o      = '0;
    if (n_rst_i) begin
      ie_type_o    = ieType_q;
      trap_cause_o = cause_q;
      epc_o        = epc_q;
      mtval_o      = mtval_q;
      unique case (state_q)
        TRAP_IDLE: begin
          if (takeTrap) begin
            stall_o = 1'b1;
          end else if (takeMret) begin
            mstatus_ie_set_o = 1'b1;
            redirect_o       = 1'b1;
            flush_o          = 1'b1;
            redirect_pc_o    = epc_i;
          end
        end
        TRAP_SAVE: begin
          set_cause_o        = 1'b1;
          set_epc_o          = 1'b1;
          set_mtval_o        = 1'b1;
          mstatus_ie_clear_o = 1'b1;
          stall_o            = 1'b1;
          flush_o            = 1'b1;
        end
        TRAP_JUMP: begin
          redirect_o    = 1'b1;
          flush_o       = 1'b1;
          redirect_pc_o = trapTarget(mtvec_i, ieType_q, cause_q, VectoredEn);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed cases plus randomized events against a
// priority-list reference model. Honors VECTORED_MTVEC_EN when computing trap targets.
module tb_trap_ctrl;

  typedef struct {
    logic        illegal, ebreak, ecall, lmis, smis, mret;
    logic        ie, commit;
    logic        mieExt, mieSw, mieTim, mipExt, mipSw, mipTim;
    logic [31:0] excPc, commitPc, inst, addr, mtvec, epc;
  } stim_t;

  typedef struct {
    int          kind;
    logic        ieType;
    logic [3:0]  cause;
    logic [31:0] epc, mtval, target;
  } exp_t;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        commit, mret, mstatusIe;
  logic [31:0] commitPc, excPc, excInst, excAddr, mtvec, epcIn;
  logic        excIllegal, excEbreak, excEcall, excLmis, excSmis;
  logic        mieExt, mieTimer, mieSw, mipExt, mipTimer, mipSw;
  logic        setCause, ieType, setEpc, setMtval, ieClear, ieSet;
  logic        stall, flush, redirect;
  logic [3:0]  trapCause;
  logic [31:0] epcOut, mtvalOut, redirectPc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  trap_ctrl dut (
    .clk_i              (clk),
    .n_rst_i            (nRst),
    .commit_i           (commit),
    .commit_pc_i        (commitPc),
    .exc_pc_i           (excPc),
    .exc_illegal_i      (excIllegal),
    .exc_ebreak_i       (excEbreak),
    .exc_ecall_i        (excEcall),
    .exc_lmis_i         (excLmis),
    .exc_smis_i         (excSmis),
    .exc_inst_i         (excInst),
    .exc_addr_i         (excAddr),
    .mret_i             (mret),
    .mstatus_ie_i       (mstatusIe),
    .mie_ext_i          (mieExt),
    .mie_timer_i        (mieTimer),
    .mie_sw_i           (mieSw),
    .mip_ext_i          (mipExt),
    .mip_timer_i        (mipTimer),
    .mip_sw_i           (mipSw),
    .mtvec_i            (mtvec),
    .epc_i              (epcIn),
    .set_cause_o        (setCause),
    .ie_type_o          (ieType),
    .trap_cause_o       (trapCause),
    .set_epc_o          (setEpc),
    .epc_o              (epcOut),
    .set_mtval_o        (setMtval),
    .mtval_o            (mtvalOut),
    .mstatus_ie_clear_o (ieClear),
    .mstatus_ie_set_o   (ieSet),
    .stall_o            (stall),
    .flush_o            (flush),
    .redirect_o         (redirect),
    .redirect_pc_o      (redirectPc)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic stim_t quietStim();
    stim_t s;
    s.illegal = 0; s.ebreak = 0; s.ecall = 0; s.lmis = 0; s.smis = 0; s.mret = 0;
    s.ie = 0; s.commit = 0;
    s.mieExt = 0; s.mieSw = 0; s.mieTim = 0; s.mipExt = 0; s.mipSw = 0; s.mipTim = 0;
    s.excPc = 0; s.commitPc = 0; s.inst = 0; s.addr = 0; s.mtvec = 32'h200; s.epc = 0;
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    excIllegal = s.illegal; excEbreak = s.ebreak; excEcall = s.ecall;
    excLmis = s.lmis; excSmis = s.smis; mret = s.mret;
    mstatusIe = s.ie; commit = s.commit;
    mieExt = s.mieExt; mieSw = s.mieSw; mieTimer = s.mieTim;
    mipExt = s.mipExt; mipSw = s.mipSw; mipTimer = s.mipTim;
    excPc = s.excPc; commitPc = s.commitPc; excInst = s.inst; excAddr = s.addr;
    mtvec = s.mtvec; epcIn = s.epc;
  endtask

  // Reference model: walk the architectural priority lists top-down.
  function automatic exp_t predict(input stim_t s);
    exp_t e;
    logic excReq[5];
    logic irqReq[3];
    int   excCause[5];
    int   irqCause[3];
    logic [31:0] base;
    excCause = '{2, 3, 11, 4, 6};
    irqCause = '{11, 3, 7};
    excReq = '{s.illegal, s.ebreak, s.ecall, s.lmis, s.smis};
    irqReq = '{s.mieExt & s.mipExt, s.mieSw & s.mipSw, s.mieTim & s.mipTim};
    e.kind = 0; e.ieType = 0; e.cause = 0; e.epc = 0; e.mtval = 0; e.target = 0;
    for (int i = 0; i < 5; i++) begin
      if (e.kind == 0 && excReq[i]) begin
        e.kind  = 1;
        e.cause = 4'(excCause[i]);
        e.epc   = s.excPc;
        e.mtval = (i == 0) ? s.inst : (i >= 3) ? s.addr : 32'h0;
      end
    end
    if (e.kind == 0 && s.mret) e.kind = 2;
    if (e.kind == 0 && s.ie && s.commit) begin
      for (int i = 0; i < 3; i++) begin
        if (e.kind == 0 && irqReq[i]) begin
          e.kind   = 1;
          e.ieType = 1;
          e.cause  = 4'(irqCause[i]);
          e.epc    = s.commitPc;
        end
      end
    end
    base = s.mtvec & 32'hFFFF_FFFC;
    e.target = base;
`ifdef VECTORED_MTVEC_EN
    if (s.mtvec[1:0] == 2'b01 && e.ieType) e.target = base + 32'(e.cause) * 4;
`endif
    return e;
  endfunction

  // While frozen, throw random activity at the DUT; only mtvec must stay put.
  task automatic applyNoise(input logic [31:0] keepMtvec);
    stim_t n;
    n = quietStim();
    {n.illegal, n.ebreak, n.ecall, n.lmis, n.smis, n.mret} = 6'($urandom);
    {n.ie, n.commit, n.mieExt, n.mieSw, n.mieTim, n.mipExt, n.mipSw, n.mipTim} = 8'($urandom);
    n.excPc = $urandom; n.commitPc = $urandom; n.inst = $urandom;
    n.addr = $urandom; n.epc = $urandom;
    n.mtvec = keepMtvec;
    applyStimulus(n);
  endtask

  task automatic runEvent(input string tag, input stim_t s);
    exp_t e;
    e = predict(s);
    @(posedge clk); #1;
    applyStimulus(s);
    @(negedge clk);
    checkOutput({tag, ".idleStall"},    32'(stall),    32'(e.kind == 1));
    checkOutput({tag, ".idleIeSet"},    32'(ieSet),    32'(e.kind == 2));
    checkOutput({tag, ".idleRedirect"}, 32'(redirect), 32'(e.kind == 2));
    checkOutput({tag, ".idleFlush"},    32'(flush),    32'(e.kind == 2));
    if (e.kind == 2) checkOutput({tag, ".mretPc"}, redirectPc, s.epc);
    if (e.kind == 1) begin
      @(posedge clk); #1;
      applyNoise(s.mtvec);
      @(negedge clk);
      checkOutput({tag, ".saveStrobes"}, {28'h0, setCause, setEpc, setMtval, ieClear}, 32'hF);
      checkOutput({tag, ".saveStallFlush"}, {29'h0, stall, flush, redirect}, 32'h6);
      checkOutput({tag, ".saveIeSet"}, 32'(ieSet), 32'h0);
      checkOutput({tag, ".cause"},  32'(trapCause), 32'(e.cause));
      checkOutput({tag, ".ieType"}, 32'(ieType),    32'(e.ieType));
      checkOutput({tag, ".epc"},    epcOut,          e.epc);
      checkOutput({tag, ".mtval"},  mtvalOut,        e.mtval);
      @(posedge clk); #1;
      applyNoise(s.mtvec);
      @(negedge clk);
      checkOutput({tag, ".jumpCtl"}, {26'h0, redirect, flush, stall, setCause, ieClear, ieSet}, 32'h30);
      checkOutput({tag, ".target"},  redirectPc, e.target);
    end
  endtask

  initial begin
    stim_t s;
    applyStimulus(quietStim());
    nRst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.ctl", {19'h0, setCause, ieType, setEpc, setMtval, ieClear, ieSet,
                              stall, flush, redirect, trapCause}, 32'h0);
    checkOutput("reset.epc", epcOut, 32'h0);
    checkOutput("reset.mtval", mtvalOut, 32'h0);
    @(posedge clk); #1;
    nRst = 1'b1;

    s = quietStim(); s.ecall = 1; s.excPc = 32'h100; s.mtvec = 32'h200;
    runEvent("ecall", s);
    checkOutput("ecall.spotTarget", redirectPc, 32'h200);

    s = quietStim(); s.illegal = 1; s.excPc = 32'h40; s.inst = 32'hFFFF_FFFF;
    runEvent("illegal", s);

    s = quietStim(); s.lmis = 1; s.excPc = 32'h60; s.addr = 32'h1003;
    runEvent("lmis", s);

    s = quietStim(); s.ie = 1; s.commit = 1; s.mieTim = 1; s.mipTim = 1; s.commitPc = 32'h84;
    runEvent("timer", s);

    s.ie = 0;
    runEvent("timerMasked", s);

    s = quietStim(); s.ie = 1; s.commit = 1; s.mieTim = 1; s.mipTim = 1; s.commitPc = 32'h88;
    s.mtvec = 32'h201;
    runEvent("vecTimer", s);

    s = quietStim(); s.ecall = 1; s.excPc = 32'h104; s.mtvec = 32'h201;
    runEvent("vecEcall", s);
    checkOutput("vecEcall.spotTarget", redirectPc, 32'h200);

    s = quietStim(); s.mret = 1; s.epc = 32'h84;
    runEvent("mret", s);

    s = quietStim(); s.mret = 1; s.epc = 32'h84; s.illegal = 1; s.excPc = 32'h90; s.inst = 32'h1234;
    runEvent("mretIllegal", s);

    s = quietStim(); s.ie = 1; s.commit = 1; s.commitPc = 32'hC0;
    {s.mieExt, s.mieSw, s.mieTim, s.mipExt, s.mipSw, s.mipTim} = 6'h3F;
    runEvent("allIrq", s);

    s = quietStim(); s.ecall = 1; s.excPc = 32'h300;
    @(posedge clk); #1;
    applyStimulus(s);
    @(posedge clk); #1;
    applyStimulus(quietStim());
    nRst = 1'b0;
    @(negedge clk);
    checkOutput("rstSave.during", {28'h0, setCause, ieClear, stall, flush}, 32'h0);
    @(posedge clk); #1;
    nRst = 1'b1;
    @(negedge clk);
    checkOutput("rstSave.ctl", {23'h0, setCause, setEpc, setMtval, ieClear, ieSet,
                                stall, flush, redirect, ieType}, 32'h0);
    checkOutput("rstSave.regs", epcOut | mtvalOut | 32'(trapCause), 32'h0);

    for (int i = 0; i < 300; i++) begin
      s = quietStim();
      s.illegal = ($urandom_range(0, 9) == 0);
      s.ebreak  = ($urandom_range(0, 9) == 0);
      s.ecall   = ($urandom_range(0, 9) == 0);
      s.lmis    = ($urandom_range(0, 9) == 0);
      s.smis    = ($urandom_range(0, 9) == 0);
      s.mret    = ($urandom_range(0, 5) == 0);
      {s.ie, s.commit, s.mieExt, s.mieSw, s.mieTim, s.mipExt, s.mipSw, s.mipTim} = 8'($urandom);
      s.excPc = $urandom; s.commitPc = $urandom; s.inst = $urandom;
      s.addr = $urandom; s.epc = $urandom; s.mtvec = $urandom;
      runEvent("rand", s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
